// File: rtl/reg_fetch_stage.sv
// rtl/reg_fetch_stage.sv - SPU register-fetch stage: 128-entry file, busy-bit scoreboard, valid/ready output
// Optional FORWARD_EN: same-cycle writeback bypass on operand reads and on the hazard check.
module reg_fetch_stage #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    output logic              inReady,
    input  logic              immeSelIn,
    input  logic [5:0]        opCodeIn,
    input  logic [ADDR_W-1:0] raIn,
    input  logic [ADDR_W-1:0] rbIn,
    input  logic [ADDR_W-1:0] rdIn,
    input  logic [IMM_W-1:0]  immIn,
    input  logic              wrEnIn,
    input  logic              wbEn,
    input  logic [ADDR_W-1:0] wbAddr,
    input  logic [DATA_W-1:0] wbData,
    output logic              outValid,
    input  logic              outReady,
    output logic [5:0]        opCodeOut,
    output logic [ADDR_W-1:0] rdOut,
    output logic              wrEnOut,
    output logic [DATA_W-1:0] opAOut,
    output logic [DATA_W-1:0] opBOut
);
    localparam int ENTRIES = 1 << ADDR_W;
    localparam int LANES   = DATA_W / 32;

    logic [DATA_W-1:0]  rf [ENTRIES];
    logic [ENTRIES-1:0] busy;
    logic [ENTRIES-1:0] busy_clr;
    logic [ENTRIES-1:0] busy_set;
    logic [ENTRIES-1:0] busy_view;
    logic               hazard;
    logic               stall;
    logic               accept;
    logic [DATA_W-1:0]  rd_a;
    logic [DATA_W-1:0]  rd_b;
    logic [DATA_W-1:0]  opb_next;
    logic [31:0]        imm_ext;

    always_comb begin
        busy_clr = '0;
        if (wbEn) begin
            busy_clr[wbAddr] = 1'b1;
        end
    end

    always_comb begin
        busy_set = '0;
        if (accept && wrEnIn) begin
            busy_set[rdIn] = 1'b1;
        end
    end

`ifdef FORWARD_EN
    // A register retiring this cycle no longer blocks its consumers.
    assign busy_view = busy & ~busy_clr;
`else
    assign busy_view = busy;
`endif

    assign hazard  = busy_view[raIn]
                   | (~immeSelIn & busy_view[rbIn])
                   | (wrEnIn & busy_view[rdIn]);
    assign stall   = hazard | (outValid & ~outReady);
    assign inReady = rst & ~stall;
    assign accept  = inValid & inReady;

    always_comb begin
        rd_a = rf[raIn];
        rd_b = rf[rbIn];
`ifdef FORWARD_EN
        if (wbEn && (wbAddr == raIn)) begin
            rd_a = wbData;
        end
        if (wbEn && (wbAddr == rbIn)) begin
            rd_b = wbData;
        end
`endif
    end

    assign imm_ext  = {{(32-IMM_W){immIn[IMM_W-1]}}, immIn};
    assign opb_next = immeSelIn ? {LANES{imm_ext}} : rd_b;

    // The file is not reset; writebacks land even while rst is low.
    always_ff @(posedge clk) begin
        if (wbEn) begin
            rf[wbAddr] <= wbData;
        end
    end

    // Set is OR'ed after the clear so a same-address set wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            outValid  <= 1'b0;
            opCodeOut <= '0;
            rdOut     <= '0;
            wrEnOut   <= 1'b0;
            opAOut    <= '0;
            opBOut    <= '0;
        end else if (accept) begin
            outValid  <= 1'b1;
            opCodeOut <= opCodeIn;
            rdOut     <= rdIn;
            wrEnOut   <= wrEnIn;
            opAOut    <= rd_a;
            opBOut    <= opb_next;
        end else if (outReady || !outValid) begin
            outValid  <= 1'b0;
        end
    end
endmodule

// File: doc/reg_fetch_stage.md
Name: reg_fetch_stage

Overview:
- Register-fetch stage directly downstream of the decode/fetch intermediate register in the SPU pipeline.
- Takes immeSel, opCode, ra, rb, rd, the immediate field and the write flag, plus a writeback port from the final stage.
- Reads two 128-bit operands from the 128-entry unified register file and selects an immediate for operand B when needed.
- Stalls on RAW/WAW hazards via a busy-bit scoreboard; registers the result into a valid/ready output stage for execute.

Parameters:
- DATA_W, 128, register/operand width in bits; multiple of 32.
- ADDR_W, 7, register address width; entries = 2**ADDR_W.
- IMM_W, 16, immediate field width; sign-extended to 32 bits.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-low reset
- inValid  input  1  upstream instruction valid
- inReady  output  1  stage accepts this cycle
- immeSelIn  input  1  1 = operand B comes from the immediate
- opCodeIn  input  6  opcode
- raIn  input  ADDR_W  source A address
- rbIn  input  ADDR_W  source B address
- rdIn  input  ADDR_W  destination address
- immIn  input  IMM_W  immediate field
- wrEnIn  input  1  instruction writes rd
- wbEn  input  1  writeback strobe
- wbAddr  input  ADDR_W  writeback address
- wbData  input  DATA_W  writeback data
- outValid  output  1  execute-side instruction valid
- outReady  input  1  execute accepts
- opCodeOut  output  6  registered opcode
- rdOut  output  ADDR_W  registered destination
- wrEnOut  output  1  registered write flag
- opAOut  output  DATA_W  operand A
- opBOut  output  DATA_W  operand B (register or immediate)

Behaviour:
- Reset (rst=0 at posedge):
  - outValid, wrEnOut, opCodeOut, rdOut, opAOut, opBOut = 0.
  - All busy bits = 0.
  - Register file contents are not reset.
  - inReady is combinational and is 0 while rst=0.
- Reset mid-operation: any in-flight instruction is dropped and busy bits are cleared; a writeback presented in the reset cycle is still written to the file.
- hazard = busy[raIn] | (!immeSelIn & busy[rbIn]) | (wrEnIn & busy[rdIn]).
- stall = hazard | (outValid & !outReady).
- inReady = rst & !stall (combinational).
- Accept = inValid & inReady. On accept, the output register loads next posedge (latency 1):
  - outValid = 1; opCode, rd and wrEn are copied.
  - opA = RF[raIn].
  - opB = immeSelIn ? four copies of sign-extended immIn (each 32-bit lane) : RF[rbIn].
- No accept and (outReady or !outValid): outValid <- 0; data outputs hold their last value.
- Stall with outValid & !outReady: all outputs hold.
- Writeback: on wbEn at posedge, RF[wbAddr] <= wbData and busy[wbAddr] is cleared.
- Scoreboard set: on accept with wrEnIn, busy[rdIn] <= 1.
- Simultaneous set and clear on the same address in one cycle: set wins.
- Operand reads are combinational from the file at the accept cycle.
- The read address and the writeback address may collide in the same cycle; the result is defined under the optional feature below.

Optional Feature:
- FORWARD_EN defined:
  - Write-through bypass: if wbEn and wbAddr equals raIn (or rbIn), the corresponding operand takes wbData in that cycle.
  - hazard uses busy bits with the same-cycle clear applied: a register whose busy bit is being cleared by wbEn this cycle counts as not busy.
- FORWARD_EN undefined:
  - No bypass; reads return the pre-write file contents.
  - hazard uses the registered busy bits, so an instruction dependent on the writeback issues one cycle after wbEn.

Test Plan:
- Reset, then write RF[5]=0x1111..., RF[6]=0x2222...; issue ra=5, rb=6, immeSel=0, opCode=0x18 -> next cycle outValid=1, opA=0x1111..., opB=0x2222....
- immeSel=1, immIn=0xFFF0 -> opB=0xFFFFFFF0 in all four lanes; busy[rb] ignored.
- Issue rd=10 wrEn=1, then ra=10 -> inReady=0 until wbEn addr 10. With FORWARD_EN: issues in the wbEn cycle and opA=wbData. Without it: issues the next cycle and opA=wbData.
- Hold outReady=0 with outValid=1 for 3 cycles -> outputs stable, inReady=0; after outReady=1, the next instruction is accepted.
- Same cycle: accept rd=7 wrEn=1 and wbEn addr 7 -> busy[7]=1 afterwards.
- Assert rst=0 mid-stall with busy bits set -> next cycle outValid=0, all busy bits 0, inReady=1 after rst returns to 1.
